// File: rtl/conv_mac_accumulator_pkg.sv
// Shared types and helpers for the convolution MAC accumulator.
// Tag bundle carried alongside each tap/close event through the pipeline.
package conv_mac_accumulator_pkg;

   localparam int BYTE           = 8;
   localparam int ACC_W_DEF      = 32;
   localparam int CONV_IN_CH_DEF = 3;

   typedef struct packed {
      logic            tap;
      logic            close;
      logic [BYTE-1:0] i;
      logic [BYTE-1:0] j;
      logic [BYTE-1:0] k;
   } tag_t;

   function automatic int idx3(
      input int a,
      input int b,
      input int c,
      input int dim
   );
      return (a * dim + b) * dim + c;
   endfunction

endpackage

// File: rtl/conv_mac_accumulator_if.sv
// Iterator, memory and output-port bundle of the MAC accumulator.
// master = iterator/memory side, slave = accumulator.
interface conv_mac_accumulator_if
   import conv_mac_accumulator_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int ACC_W  = ACC_W_DEF
);

   logic                    en_ctrl;
   logic                    en_sum;
   logic                    finish;
   logic [BYTE-1:0]         i;
   logic [BYTE-1:0]         j;
   logic [BYTE-1:0]         k;
   logic [BYTE-1:0]         l;
   logic [BYTE-1:0]         m;
   logic [BYTE-1:0]         n;
   logic signed [BYTE-1:0]  in_row;
   logic signed [BYTE-1:0]  in_col;
   logic [ADDR_W-1:0]       img_addr;
   logic [ADDR_W-1:0]       wgt_addr;
   logic signed [BYTE-1:0]  img_data;
   logic signed [BYTE-1:0]  wgt_data;
   logic [BYTE-1:0]         bias_addr;
   logic signed [ACC_W-1:0] bias_data;
   logic [ADDR_W-1:0]       out_addr;
   logic signed [BYTE-1:0]  out_data;
   logic                    out_valid;
   logic                    done;

   modport master (
      output en_ctrl, en_sum, finish,
      output i, j, k, l, m, n, in_row, in_col,
      output img_data, wgt_data, bias_data,
      input  img_addr, wgt_addr, bias_addr,
      input  out_addr, out_data, out_valid, done
   );

   modport slave (
      input  en_ctrl, en_sum, finish,
      input  i, j, k, l, m, n, in_row, in_col,
      input  img_data, wgt_data, bias_data,
      output img_addr, wgt_addr, bias_addr,
      output out_addr, out_data, out_valid, done
   );

endinterface

// File: rtl/conv_requant.sv
// Window requantisation: bias add, arithmetic shift, ReLU, 8-bit saturate.
module conv_requant
   import conv_mac_accumulator_pkg::*;
#(
   parameter int ACC_W     = ACC_W_DEF,
   parameter int OUT_SHIFT = 7
) (
   input  logic signed [ACC_W-1:0] acc_i,
   input  logic signed [ACC_W-1:0] bias_i,
   output logic signed [BYTE-1:0]  pix_o
);

   localparam logic signed [ACC_W-1:0] SAT_MAX = 127;

   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] shifted;

   assign sum     = acc_i + bias_i;
   assign shifted = sum >>> OUT_SHIFT;

   always_comb begin
      pix_o = shifted[BYTE-1:0];
      unique case (1'b1)
         shifted[ACC_W-1]:    pix_o = '0;
         (shifted > SAT_MAX): pix_o = 8'sd127;
         default: ;
      endcase
   end

endmodule

// File: rtl/conv_mac_accumulator.sv
// Per-window signed MAC over iterator taps; emits one requantised pixel
// with its output address when the window closes.
module conv_mac_accumulator
   import conv_mac_accumulator_pkg::*;
#(
   parameter int CONV_DIM_IMG    = 32,
   parameter int CONV_DIM_OUT    = 32,
   parameter int CONV_DIM_KERNEL = 5,
   parameter int CONV_IN_CH      = CONV_IN_CH_DEF,
   parameter int CONV_OUT_CH     = 32,
   parameter int ACC_W           = ACC_W_DEF,
   parameter int OUT_SHIFT       = 7,
   parameter int ADDR_W          = 16
) (
   input logic                   clk,
   input logic                   reset,
   conv_mac_accumulator_if.slave bus
);

   localparam int PW = 2 * BYTE;
   localparam logic [BYTE-1:0] K_LAST = BYTE'(CONV_DIM_KERNEL - 1);

   tag_t                    s0_q, s0_d;
   tag_t                    s1_q, s1_d;
   logic signed [PW-1:0]    prod_q, prod_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] prod_ext;
   logic                    out_valid_q, out_valid_d;
   logic signed [BYTE-1:0]  out_data_q, out_data_d;
   logic [ADDR_W-1:0]       out_addr_q, out_addr_d;
   logic                    done_q, done_d;
   logic signed [BYTE-1:0]  req_pix;
   logic                    tap, close;
   logic                    s0_busy, s1_busy;
   logic                    unused_cfg;

   // output channel count only bounds the iterator's i range
   assign unused_cfg = ^32'(CONV_OUT_CH);

   assign bus.img_addr = ADDR_W'(idx3(int'(bus.l), int'(bus.in_row),
                                      int'(bus.in_col), CONV_DIM_IMG));
   assign bus.wgt_addr = ADDR_W'(idx3(int'(bus.i) * CONV_IN_CH + int'(bus.l),
                                      int'(bus.m), int'(bus.n),
                                      CONV_DIM_KERNEL));

   assign tap   = bus.en_ctrl & bus.en_sum;
   assign close = bus.en_ctrl & ~bus.finish & ~bus.en_sum &
                  (bus.m == K_LAST) & (bus.n == K_LAST);

   assign s0_busy  = s0_q.tap | s0_q.close;
   assign s1_busy  = s1_q.tap | s1_q.close;
   assign prod_ext = ACC_W'(prod_q);

   conv_requant #(
      .ACC_W     (ACC_W),
      .OUT_SHIFT (OUT_SHIFT)
   ) u_requant (
      .acc_i  (acc_q),
      .bias_i (bus.bias_data),
      .pix_o  (req_pix)
   );

   always_comb begin
      s0_d.tap    = tap;
      s0_d.close  = close;
      s0_d.i      = bus.i;
      s0_d.j      = bus.j;
      s0_d.k      = bus.k;
      s1_d        = s0_q;
      prod_d      = PW'(bus.img_data) * PW'(bus.wgt_data);
      acc_d       = acc_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      // a close clears acc here, so the next window's first tap lands on 0
      unique case (1'b1)
         s1_q.tap: acc_d = acc_q + prod_ext;
         s1_q.close: begin
            acc_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = req_pix;
            out_addr_d  = ADDR_W'(idx3(int'(s1_q.i), int'(s1_q.j),
                                       int'(s1_q.k), CONV_DIM_OUT));
         end
         default: ;
      endcase
      done_d = done_q | (bus.finish & ~tap & ~s0_busy & ~s1_busy);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s0_q        <= '0;
         s1_q        <= '0;
         prod_q      <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         s0_q        <= s0_d;
         s1_q        <= s1_d;
         prod_q      <= prod_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         done_q      <= done_d;
      end
   end

   // bias is looked up one stage early to meet its 1-cycle read latency
   assign bus.bias_addr = s0_q.i;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_conv_mac_accumulator.sv
// Directed bench: two accumulators (shift 0 and shift 7) fed by an
// iterator-style driver on a 4x4 image, 3x3 kernel, padding 1.
module tb_conv_mac_accumulator;

   localparam int IMG  = 4;
   localparam int OUTD = 4;
   localparam int KD   = 3;
   localparam int CH   = 3;
   localparam int OCH  = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   conv_mac_accumulator_if #(.ADDR_W(16), .ACC_W(32)) if0 ();
   conv_mac_accumulator_if #(.ADDR_W(16), .ACC_W(32)) if7 ();

   conv_mac_accumulator #(
      .CONV_DIM_IMG(IMG), .CONV_DIM_OUT(OUTD), .CONV_DIM_KERNEL(KD),
      .CONV_IN_CH(CH), .CONV_OUT_CH(OCH), .ACC_W(32),
      .OUT_SHIFT(0), .ADDR_W(16)
   ) u0 (.clk(clk), .reset(reset), .bus(if0));

   conv_mac_accumulator #(
      .CONV_DIM_IMG(IMG), .CONV_DIM_OUT(OUTD), .CONV_DIM_KERNEL(KD),
      .CONV_IN_CH(CH), .CONV_OUT_CH(OCH), .ACC_W(32),
      .OUT_SHIFT(7), .ADDR_W(16)
   ) u7 (.clk(clk), .reset(reset), .bus(if7));

   logic en_ctrl, en_sum, finish;
   logic [7:0] ti, tj, tk, tl, tm, tn;
   logic signed [7:0] row, col;
   logic signed [7:0] img_val, wgt_val;
   int bias_v [2];

   assign if0.en_ctrl = en_ctrl;
   assign if7.en_ctrl = en_ctrl;
   assign if0.en_sum  = en_sum;
   assign if7.en_sum  = en_sum;
   assign if0.finish  = finish;
   assign if7.finish  = finish;
   assign if0.i = ti;
   assign if7.i = ti;
   assign if0.j = tj;
   assign if7.j = tj;
   assign if0.k = tk;
   assign if7.k = tk;
   assign if0.l = tl;
   assign if7.l = tl;
   assign if0.m = tm;
   assign if7.m = tm;
   assign if0.n = tn;
   assign if7.n = tn;
   assign if0.in_row = row;
   assign if7.in_row = row;
   assign if0.in_col = col;
   assign if7.in_col = col;

   // 1-cycle-latency memories; image/weight contents are uniform per test
   always @(posedge clk) begin
      if0.img_data  <= img_val;
      if7.img_data  <= img_val;
      if0.wgt_data  <= wgt_val;
      if7.wgt_data  <= wgt_val;
      if0.bias_data <= bias_v[if0.bias_addr[0]];
      if7.bias_data <= bias_v[if7.bias_addr[0]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int   cyc;
      int   addr;
      int   d0;
      int   d7;
      logic v7;
      logic dn;
   } rec_t;

   rec_t act_q[$];
   rec_t exp_q[$];
   rec_t mon;

   always @(negedge clk) begin
      if (if0.out_valid === 1'b1) begin
         mon.cyc  = cyc;
         mon.addr = int'(if0.out_addr);
         mon.d0   = int'(if0.out_data);
         mon.d7   = int'(if7.out_data);
         mon.v7   = if7.out_valid;
         mon.dn   = if0.done;
         act_q.push_back(mon);
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic window(input int ii, input int jj, input int kk,
                         input int e0, input int e7);
      int r, c;
      bit pad;
      rec_t e;
      for (int l = 0; l < CH; l++)
         for (int m = 0; m < KD; m++)
            for (int n = 0; n < KD; n++) begin
               r   = jj - 1 + m;
               c   = kk - 1 + n;
               pad = (r < 0) || (r >= IMG) || (c < 0) || (c >= IMG);
               // the iterator never shows a padding tap on the last kernel slot
               if (pad && m == KD - 1 && n == KD - 1) continue;
               en_ctrl = 1'b1;
               en_sum  = !pad;
               ti = 8'(ii); tj = 8'(jj); tk = 8'(kk);
               tl = 8'(l);  tm = 8'(m);  tn = 8'(n);
               row = 8'(r); col = 8'(c);
               step();
            end
      en_ctrl = 1'b1;
      en_sum  = 1'b0;
      tl = 8'(CH - 1);
      tm = 8'(KD - 1);
      tn = 8'(KD - 1);
      e.cyc  = cyc;
      e.addr = (ii * OUTD + jj) * OUTD + kk;
      e.d0   = e0;
      e.d7   = e7;
      e.v7   = 1'b1;
      e.dn   = 1'b0;
      exp_q.push_back(e);
      step();
      en_ctrl = 1'b0;
   endtask

   task automatic collect(input string tag);
      int t;
      rec_t a, e;
      t = 0;
      while (act_q.size() < exp_q.size() && t < 40) begin
         step();
         t++;
      end
      repeat (4) step();
      chk({tag, "/count"}, act_q.size(), exp_q.size());
      while (exp_q.size() > 0 && act_q.size() > 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         chk({tag, "/latency"}, a.cyc - e.cyc, 3);
         chk({tag, "/addr"}, a.addr, e.addr);
         chk({tag, "/data_sh0"}, a.d0, e.d0);
         chk({tag, "/data_sh7"}, a.d7, e.d7);
         chk({tag, "/valid_sh7"}, a.v7, e.v7);
         chk({tag, "/done_at_pulse"}, a.dn, e.dn);
      end
      act_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int cnt;
      reset   = 1'b1;
      en_ctrl = 1'b0;
      en_sum  = 1'b0;
      finish  = 1'b0;
      ti = '0; tj = '0; tk = '0; tl = '0; tm = '0; tn = '0;
      row = '0; col = '0;
      img_val = 8'sd1;
      wgt_val = 8'sd1;
      bias_v[0] = 0;
      bias_v[1] = 0;
      step();
      step();

      chk("rst/out_valid", if0.out_valid, 0);
      chk("rst/done", if0.done, 0);
      chk("rst/out_data", if0.out_data, 0);
      chk("rst/out_addr", if0.out_addr, 0);
      chk("rst/bias_addr", if0.bias_addr, 0);
      chk("rst/done_sh7", if7.done, 0);

      tl = 8'd2; row = 8'sd2; col = 8'sd3;
      ti = 8'd1; tm = 8'd1; tn = 8'd0;
      #1;
      chk("addr/img", if0.img_addr, 43);
      chk("addr/wgt", if0.wgt_addr, 48);
      tl = 8'd0; row = -8'sd1; col = 8'sd0;
      #1;
      chk("addr/img_neg", if0.img_addr, 65532);
      reset = 1'b0;
      step();

      // taps offered while en_ctrl is low must be ignored
      en_ctrl = 1'b0;
      en_sum  = 1'b1;
      tm = 8'd0; tn = 8'd0; row = 8'sd0; col = 8'sd0;
      repeat (3) step();
      en_sum = 1'b0;
      window(0, 0, 0, 12, 0);
      window(0, 1, 1, 27, 0);
      collect("ones");

      img_val = 8'sd100;
      wgt_val = 8'sd100;
      window(0, 1, 1, 127, 127);
      collect("sat");

      img_val = 8'sd10;
      wgt_val = 8'sd10;
      bias_v[1] = 300;
      window(1, 1, 1, 127, 23);
      window(1, 0, 0, 127, 11);
      collect("bias_ch1");

      img_val = 8'sd1;
      wgt_val = -8'sd1;
      bias_v[0] = 5;
      bias_v[1] = 5;
      window(0, 1, 1, 0, 0);
      window(0, 0, 0, 0, 0);
      collect("relu");

      bias_v[0] = 130;
      window(0, 0, 3, 118, 0);
      collect("lowbits");

      bias_v[0] = 5000;
      window(0, 1, 1, 127, 38);
      collect("shift");

      img_val = 8'sd1;
      wgt_val = 8'sd1;
      bias_v[0] = 0;
      bias_v[1] = 0;
      for (int ii = 0; ii < OCH; ii++)
         for (int jj = 0; jj < OUTD; jj++)
            for (int kk = 0; kk < OUTD; kk++) begin
               cnt = 0;
               for (int m = 0; m < KD; m++)
                  for (int n = 0; n < KD; n++)
                     if (jj - 1 + m >= 0 && jj - 1 + m < IMG &&
                         kk - 1 + n >= 0 && kk - 1 + n < IMG)
                        cnt++;
               window(ii, jj, kk, CH * cnt, 0);
            end
      finish = 1'b1;
      chk("full/done_early", if0.done, 0);
      collect("full");
      chk("full/done", if0.done, 1);
      chk("full/done_sh7", if7.done, 1);
      repeat (3) step();
      chk("full/done_sticky", if0.done, 1);

      finish = 1'b0;
      window(0, 1, 1, 27, 0);
      reset = 1'b1;
      exp_q.delete();
      step();
      chk("abort/done", if0.done, 0);
      chk("abort/out_valid", if0.out_valid, 0);
      reset = 1'b0;
      collect("abort");
      chk("abort/done_after", if0.done, 0);
      window(0, 0, 0, 12, 0);
      collect("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
